// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: FSM states, the fault filler instruction and the
// buffered fetch entry that the decoder also consumes.
package fetch_pkg;

   localparam int          FETCH_XLEN = 32;
   localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

   typedef enum logic [1:0] {
      RUN,
      FAULT,
      HALT
   } fetch_state_t;

   typedef struct packed {
      logic [FETCH_XLEN-1:0] instr;
      logic [FETCH_XLEN-1:0] pc;
      logic                  misaligned;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with single-cycle flush and occupancy count.
// A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 65,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_q, wr_q;
   logic [CW-1:0]    cnt_q;
   logic             full, do_push, do_pop;

   assign empty_o = (cnt_q == '0);
   assign full    = (cnt_q == CW'(DEPTH));
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full || do_pop);
   assign data_o  = mem_q[rd_q];
   assign count_o = cnt_q;

   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + AW'(1);
         if (do_pop)  rd_q <= rd_q + AW'(1);
         cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= data_i;
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues credit-limited word requests, buffers
// responses tagged with their PC and handles redirects and misaligned-target faults.
module instruction_fetch_unit #(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
   parameter int              FIFO_DEPTH = 2,
   parameter logic [XLEN-1:0] NOP_INSTR  = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            rst,
   output logic            im_req_valid,
   input  logic            im_req_ready,
   output logic [XLEN-1:0] im_addr,
   input  logic            im_rsp_valid,
   input  logic [XLEN-1:0] im_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] instruction,
   output logic [XLEN-1:0] PC,
   output logic            id_misaligned
);
   import fetch_pkg::*;

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int SW = CW + 1;

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] tag_pc_q, tag_pc_d;
   logic [CW-1:0]   out_cnt_q, out_cnt_d;
   logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
   logic [CW-1:0]   fifo_cnt;
   logic            fifo_empty, push, pop, req_fire, rsp_fire;
   fetch_entry_t    push_entry, head;

   // Responses with nothing outstanding (e.g. left over from before a reset) are ignored.
   assign rsp_fire     = im_rsp_valid && (out_cnt_q != '0);
   assign im_req_valid = !rst && (state_q == RUN) && !redirect_valid &&
                         ((SW'(out_cnt_q) + SW'(fifo_cnt)) < SW'(FIFO_DEPTH));
   assign req_fire     = im_req_valid && im_req_ready;
   assign im_addr      = fetch_pc_q;

   assign id_valid      = !fifo_empty;
   assign instruction   = id_valid ? head.instr      : '0;
   assign PC            = id_valid ? head.pc         : '0;
   assign id_misaligned = id_valid ? head.misaligned : 1'b0;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      tag_pc_d   = tag_pc_q;
      out_cnt_d  = out_cnt_q + CW'(req_fire) - CW'(rsp_fire);
      drop_cnt_d = drop_cnt_q;
      push       = 1'b0;
      pop        = id_valid && id_ready;
      push_entry = '{instr: im_rsp_data, pc: tag_pc_q, misaligned: 1'b0};
      if (redirect_valid) begin
         // Everything still in flight becomes stale; a response arriving now is dropped directly.
         pop        = 1'b0;
         fetch_pc_d = redirect_pc;
         tag_pc_d   = redirect_pc;
         drop_cnt_d = out_cnt_q - CW'(rsp_fire);
         state_d    = (redirect_pc[1:0] != 2'b00) ? FAULT : RUN;
      end else begin
         if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
         if (rsp_fire) begin
            if (drop_cnt_q != '0) begin
               drop_cnt_d = drop_cnt_q - CW'(1);
            end else begin
               push     = 1'b1;
               tag_pc_d = tag_pc_q + XLEN'(4);
            end
         end
         // In FAULT every outstanding response is stale, so this never collides with a response push.
         if ((state_q == FAULT) && (drop_cnt_q == '0) && fifo_empty) begin
            push       = 1'b1;
            push_entry = '{instr: NOP_INSTR, pc: fetch_pc_q, misaligned: 1'b1};
            state_d    = HALT;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RUN;
         fetch_pc_q <= RESET_PC;
         tag_pc_q   <= RESET_PC;
         out_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         tag_pc_q   <= tag_pc_d;
         out_cnt_q  <= out_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(fetch_entry_t))
   ) u_ibuf (
      .clk     (clk),
      .rst     (rst),
      .flush_i (redirect_valid),
      .push_i  (push),
      .data_i  (push_entry),
      .pop_i   (pop),
      .data_o  (head),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt)
   );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit against a queue-based model of
// in-flight requests (with stale marks) and the instruction buffer.
module tb_instruction_fetch_unit;

   localparam int          D    = 2;
   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] RPC  = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst, im_req_valid, im_req_ready, im_rsp_valid, redirect_valid;
   logic        id_valid, id_ready, id_misaligned;
   logic [31:0] im_addr, im_rsp_data, redirect_pc, instruction, PC;

   always #5 clk = ~clk;

   instruction_fetch_unit #(
      .XLEN(32), .RESET_PC(RPC), .FIFO_DEPTH(D), .NOP_INSTR(NOP)
   ) dut (
      .clk(clk), .rst(rst),
      .im_req_valid(im_req_valid), .im_req_ready(im_req_ready), .im_addr(im_addr),
      .im_rsp_valid(im_rsp_valid), .im_rsp_data(im_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .id_valid(id_valid), .id_ready(id_ready), .instruction(instruction),
      .PC(PC), .id_misaligned(id_misaligned)
   );

   typedef struct { logic [31:0] instr; logic [31:0] pc; logic mis; } ent_t;
   typedef struct { logic [31:0] pc; bit stale; } fl_t;
   typedef struct { logic [31:0] addr; int due; } mreq_t;

   ent_t  m_fifo[$];
   fl_t   m_fl[$];
   mreq_t mem_q[$];
   logic [31:0] m_pc;
   int    m_mode;                  // 0 fetching, 1 fault pending, 2 halted
   bit    exp_req_v;

   int n_chk = 0, n_fail = 0, cyc = 0, pr = 0;
   int lat = 1, rdy_pct = 100, idr_pct = 100, spur_pct = 0;
   bit rst_req = 1'b1, prev_rst = 1'b0, boot = 1'b1;
   bit pend_redir = 1'b0, coinc_mode = 1'b0, first_on = 1'b0, cnt_en = 1'b0;
   logic [31:0] pend_pc, first_pc;
   int flush_cd = 0, wrap_cd = 0, req_cnt = 0, mem_rsp;

   function automatic logic [31:0] mdata(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic check();
      exp_req_v = !rst && (m_mode == 0) && !redirect_valid && ((m_fl.size() + m_fifo.size()) < D);
      if (!rst) begin
         chk("im_req_valid", im_req_valid, exp_req_v);
         chk("im_addr", im_addr, m_pc);
         chk("id_valid", id_valid, m_fifo.size() > 0);
         if (m_fifo.size() > 0) begin
            chk("instruction", instruction, m_fifo[0].instr);
            chk("PC", PC, m_fifo[0].pc);
            chk("id_misaligned", id_misaligned, m_fifo[0].mis);
         end
         chk("outstanding_cap", (mem_q.size() + mem_rsp) <= D, 1);
         if (cnt_en) req_cnt += im_req_valid;
         if (boot && pr == 0) begin
            chk("boot_req_valid", im_req_valid, 1);
            chk("boot_addr", im_addr, RPC);
         end
         if (boot && pr == 1) chk("boot_addr2", im_addr, RPC + 4);
         if (boot && pr == 2) begin
            chk("boot_id_valid", id_valid, 1);
            chk("boot_pc", PC, RPC);
            chk("boot_instr", instruction, mdata(RPC));
         end
         if (first_on && id_valid) begin
            chk("first_pc_after_redirect", PC, first_pc);
            first_on = 1'b0;
         end
         if (flush_cd == 1) chk("flush_coincident_empty", id_valid, 0);
         if (wrap_cd == 1) chk("pc_wrap", im_addr, 32'h0);
      end else if (prev_rst) begin
         chk("rst_req_valid", im_req_valid, 0);
         chk("rst_id_valid", id_valid, 0);
         chk("rst_instr", instruction, 0);
         chk("rst_pc", PC, 0);
         chk("rst_mis", id_misaligned, 0);
         chk("rst_addr", im_addr, RPC);
      end
      if (flush_cd > 0) flush_cd--;
      if (wrap_cd > 0) wrap_cd--;
   endtask

   task automatic model_update();
      bit   rspf, fault_go;
      int   nstale;
      fl_t  h;
      if (rst) begin
         m_pc = RPC; m_mode = 0; m_fifo.delete(); m_fl.delete(); first_on = 1'b0;
         return;
      end
      rspf = im_rsp_valid && (m_fl.size() > 0);
      if (redirect_valid) begin
         if (rspf) void'(m_fl.pop_front());
         foreach (m_fl[i]) m_fl[i].stale = 1'b1;
         m_fifo.delete();
         m_pc = redirect_pc;
         m_mode = (redirect_pc[1:0] != 2'b00) ? 1 : 0;
         first_on = 1'b1; first_pc = redirect_pc;
      end else begin
         nstale = 0;
         foreach (m_fl[i]) nstale += m_fl[i].stale;
         fault_go = (m_mode == 1) && (m_fifo.size() == 0) && (nstale == 0);
         if (m_fifo.size() > 0 && id_ready) void'(m_fifo.pop_front());
         if (rspf) begin
            h = m_fl.pop_front();
            if (!h.stale) m_fifo.push_back('{im_rsp_data, h.pc, 1'b0});
         end
         if (fault_go) begin
            m_fifo.push_back('{NOP, m_pc, 1'b1});
            m_mode = 2;
         end
         if (exp_req_v && im_req_ready) begin
            m_fl.push_back('{m_pc, 1'b0});
            m_pc = m_pc + 32'd4;
         end
      end
   endtask

   task automatic cycle();
      bit fire;
      logic [31:0] a;
      @(negedge clk);
      rst = rst_req;
      im_rsp_valid = 1'b0; im_rsp_data = '0; mem_rsp = 0;
      if (rst) mem_q.delete();
      if (!rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         im_rsp_valid = 1'b1; im_rsp_data = mdata(mem_q[0].addr); mem_rsp = 1;
         void'(mem_q.pop_front());
      end else if (m_fl.size() == 0 && $urandom_range(99) < spur_pct) begin
         im_rsp_valid = 1'b1; im_rsp_data = $urandom;
      end
      im_req_ready = ($urandom_range(99) < rdy_pct);
      id_ready     = ($urandom_range(99) < idr_pct);
      redirect_valid = 1'b0;
      if (pend_redir) begin
         redirect_valid = 1'b1; redirect_pc = pend_pc; pend_redir = 1'b0;
      end else if (coinc_mode && !rst && mem_rsp == 1 && m_fifo.size() > 0) begin
         redirect_valid = 1'b1; redirect_pc = 32'h300; id_ready = 1'b1;
         coinc_mode = 1'b0; flush_cd = 2;
      end
      #1 check();
      fire = im_req_valid && im_req_ready;
      a = im_addr;
      @(posedge clk);
      model_update();
      if (fire && !rst) begin
         mem_q.push_back('{a, cyc + lat});
         if (a == 32'hFFFF_FFFC) wrap_cd = 2;
      end
      pr = rst ? 0 : pr + 1;
      prev_rst = rst;
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic redirect(input logic [31:0] pc);
      pend_redir = 1'b1; pend_pc = pc;
      cycle();
   endtask

   initial begin
      rst = 1'b1; im_req_ready = 0; im_rsp_valid = 0; im_rsp_data = '0;
      redirect_valid = 0; redirect_pc = '0; id_ready = 0;
      m_pc = RPC; m_mode = 0;
      run(3);
      rst_req = 1'b0;
      run(20);
      boot = 1'b0;

      // Decoder stalls: buffer fills, requests stop, head held.
      idr_pct = 0;   run(6);
      idr_pct = 100; run(10);

      // Slow memory with ready toggling.
      lat = 3; rdy_pct = 50; idr_pct = 80; run(60);

      // Redirect with two requests in flight.
      rdy_pct = 100; idr_pct = 100;
      begin
         int k;
         for (k = 0; k < 50 && m_fl.size() != 2; k++) cycle();
         chk("reach_two_outstanding", m_fl.size(), 2);
      end
      redirect(32'h100);
      run(15);

      // Redirect coincident with a response and a pop.
      lat = 1; idr_pct = 50; coinc_mode = 1'b1;
      for (int k = 0; k < 80 && coinc_mode; k++) cycle();
      chk("coincident_redirect_seen", coinc_mode, 0);
      coinc_mode = 1'b0;
      run(10);

      // Misaligned target: single fault entry, no requests until a new redirect.
      idr_pct = 100;
      redirect(32'h102);
      cnt_en = 1'b1; req_cnt = 0;
      run(12);
      cnt_en = 1'b0;
      chk("fault_no_requests", req_cnt, 0);
      redirect(32'h200);
      run(20);

      // PC wrap.
      redirect(32'hFFFF_FFF8);
      run(10);

      // Reset with requests outstanding, plus stray responses.
      lat = 3;
      for (int k = 0; k < 20 && m_fl.size() == 0; k++) cycle();
      spur_pct = 60;
      rst_req = 1'b1; run(2);
      rst_req = 1'b0; run(25);

      // Random mix.
      spur_pct = 20;
      for (int seg = 0; seg < 8; seg++) begin
         lat = $urandom_range(4, 1); rdy_pct = $urandom_range(100, 30); idr_pct = $urandom_range(100, 30);
         for (int k = 0; k < 60; k++) begin
            if ($urandom_range(99) < 4) begin
               pend_redir = 1'b1;
               pend_pc = {20'h0, 10'($urandom), ($urandom_range(9) == 0) ? 2'b10 : 2'b00};
            end
            cycle();
         end
         if (m_mode == 2) redirect(32'h400);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
